// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table: two-bit
// saturating counter encoding, its reset value and the update rule.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;  // strong not-taken
  localparam ctr_t WNT = 2'b01;  // weak not-taken
  localparam ctr_t WT  = 2'b10;  // weak taken
  localparam ctr_t ST  = 2'b11;  // strong taken

  localparam ctr_t CTR_RST = WNT;

  localparam int STAT_W = 16;

  // Move one step toward the actual outcome, holding at the extremes.
  function automatic ctr_t ctr_next(ctr_t s, logic taken);
    ctr_t r;
    r = s;
    if (taken) begin
      if (s != ST) r = s + 2'd1;
    end else begin
      if (s != SNT) r = s - 2'd1;
    end
    return r;
  endfunction

  // Statistics counter increment that sticks at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Lookup/update/statistics bundle between fetch+execute and the BHT.
// master = the pipeline side, slave = the predictor.
interface bht_predictor_if
  import bp_pkg::*;
#(
  parameter int PC_W = 32
) ();

  logic              lkp_vld;
  logic [PC_W-1:0]   lkp_pc;
  logic              pred_vld;
  logic              pred_taken;
  ctr_t              pred_stt;

  logic              upd_vld;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic              upd_pred_taken;
  logic              mispredict;

  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] mis_cnt;

  modport master (
    output lkp_vld, lkp_pc, upd_vld, upd_pc, upd_taken, upd_pred_taken,
    input  pred_vld, pred_taken, pred_stt, mispredict, br_cnt, mis_cnt
  );

  modport slave (
    input  lkp_vld, lkp_pc, upd_vld, upd_pc, upd_taken, upd_pred_taken,
    output pred_vld, pred_taken, pred_stt, mispredict, br_cnt, mis_cnt
  );

endinterface

// File: rtl/bht_ctr_next.sv
// Next-state logic for one saturating counter on the update path.
module bht_ctr_next
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  assign nxt = ctr_next(cur, taken);

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: ENTRIES two-bit counters in flops, one-cycle
// lookup with write-first bypass, one update per cycle, and saturating
// branch / mispredict statistics.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int IDX_LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  bht_predictor_if.slave   bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]          lkp_idx;
  logic [IDX_W-1:0]          upd_idx;
  logic [ENTRIES-1:0][1:0]   ctr_vec;
  ctr_t                      upd_cur;
  ctr_t                      upd_new;
  ctr_t                      lkp_next;

  logic                      pred_vld_reg;
  ctr_t                      pred_stt_reg;
  logic                      mispredict_reg;
  logic [STAT_W-1:0]         br_cnt_reg;
  logic [STAT_W-1:0]         mis_cnt_reg;

  assign lkp_idx = bus.lkp_pc[IDX_LSB +: IDX_W];
  assign upd_idx = bus.upd_pc[IDX_LSB +: IDX_W];
  assign upd_cur = ctr_vec[upd_idx];

  // Single next-state instance; its result feeds both the array write
  // and the same-index lookup bypass so the two can never disagree.
  bht_ctr_next u_ctr_next (
    .cur   (upd_cur),
    .taken (bus.upd_taken),
    .nxt   (upd_new)
  );

  // One counter per entry; flops rather than RAM so reset can preload WNT.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
    ctr_t ctr_reg;
    logic wr_en;

    assign wr_en       = bus.upd_vld && (upd_idx == IDX_W'(gi));
    assign ctr_vec[gi] = ctr_reg;

    // Write the indexed counter at the edge that samples the update.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     ctr_reg <= CTR_RST;
      else if (wr_en) ctr_reg <= upd_new;
    end
  end

  // Lookup source: post-update value when hitting the entry being written.
  always_comb begin
    lkp_next = ctr_vec[lkp_idx];
    if (bus.upd_vld && (upd_idx == lkp_idx)) lkp_next = upd_new;
  end

  // Register the prediction; state holds its last value between lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld_reg <= 1'b0;
      pred_stt_reg <= CTR_RST;
    end else begin
      pred_vld_reg <= bus.lkp_vld;
      if (bus.lkp_vld) pred_stt_reg <= lkp_next;
    end
  end

  // Mispredict pulse and saturating statistics, updated with the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_reg <= 1'b0;
      br_cnt_reg     <= '0;
      mis_cnt_reg    <= '0;
    end else begin
      mispredict_reg <= bus.upd_vld && (bus.upd_taken != bus.upd_pred_taken);
      if (bus.upd_vld) begin
        br_cnt_reg <= sat_inc(br_cnt_reg);
        if (bus.upd_taken != bus.upd_pred_taken) mis_cnt_reg <= sat_inc(mis_cnt_reg);
      end
    end
  end

  assign bus.pred_vld   = pred_vld_reg;
  assign bus.pred_stt   = pred_stt_reg;
  assign bus.pred_taken = pred_stt_reg[1];
  assign bus.mispredict = mispredict_reg;
  assign bus.br_cnt     = br_cnt_reg;
  assign bus.mis_cnt    = mis_cnt_reg;

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed steps from the test
// plan plus random traffic, compared against an array-based model.
module tb_bht_predictor;

  localparam int ENTRIES = 16;
  localparam int PC_W    = 32;
  localparam int IDX_LSB = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  bht_predictor_if #(.PC_W(PC_W)) bus ();

  bht_predictor #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .IDX_LSB (IDX_LSB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain integers per entry and for each output.
  int model [ENTRIES];
  int exp_vld, exp_stt, exp_misp, exp_br, exp_mis;

  function automatic int idx_of(logic [PC_W-1:0] pc);
    return int'((pc >> IDX_LSB) % ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model[i] = 1;
    exp_vld  = 0;
    exp_stt  = 1;
    exp_misp = 0;
    exp_br   = 0;
    exp_mis  = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pred_vld"},   32'(bus.pred_vld),   32'(exp_vld));
    check({tag, ".pred_stt"},   32'(bus.pred_stt),   32'(exp_stt));
    check({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(exp_stt / 2));
    check({tag, ".mispredict"}, 32'(bus.mispredict), 32'(exp_misp));
    check({tag, ".br_cnt"},     32'(bus.br_cnt),     32'(exp_br));
    check({tag, ".mis_cnt"},    32'(bus.mis_cnt),    32'(exp_mis));
  endtask

  task automatic idle();
    bus.lkp_vld        = 1'b0;
    bus.lkp_pc         = '0;
    bus.upd_vld        = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_pred_taken = 1'b0;
  endtask

  // One cycle: drive, clock, advance the model, then compare.
  task automatic step(input string tag, input logic lv, input logic [PC_W-1:0] lpc,
                      input logic uv, input logic [PC_W-1:0] upc,
                      input logic ut, input logic upt, input logic do_check);
    int i;
    bus.lkp_vld        = lv;
    bus.lkp_pc         = lpc;
    bus.upd_vld        = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_pred_taken = upt;
    @(posedge clk);
    exp_misp = (uv && (ut != upt)) ? 1 : 0;
    if (uv) begin
      i = idx_of(upc);
      if (ut) model[i] = (model[i] < 3) ? model[i] + 1 : 3;
      else    model[i] = (model[i] > 0) ? model[i] - 1 : 0;
      exp_br = (exp_br < 65535) ? exp_br + 1 : 65535;
      if (ut != upt) exp_mis = (exp_mis < 65535) ? exp_mis + 1 : 65535;
    end
    exp_vld = lv ? 1 : 0;
    if (lv) exp_stt = model[idx_of(lpc)];
    #1;
    if (do_check) begin
      $display("%s: lkp=%0b pc=%h upd=%0b pc=%h t=%0b pt=%0b -> vld=%0b stt=%0d misp=%0b br=%0d mis=%0d",
               tag, lv, lpc, uv, upc, ut, upt, bus.pred_vld, bus.pred_stt,
               bus.mispredict, bus.br_cnt, bus.mis_cnt);
      check_all(tag);
    end
  endtask

  initial begin
    logic [PC_W-1:0] lpc, upc;
    logic            ut;

    idle();
    model_reset();

    // Reset state, visible as soon as reset asserts.
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Lookup after reset returns weak not-taken.
    step("lkp40", 1, 32'h40, 0, 0, 0, 0, 1);
    check("lkp40.stt_const", 32'(bus.pred_stt), 32'd1);

    // Three taken updates: mispredict on the first two only.
    step("upd40a", 0, 0, 1, 32'h40, 1, 0, 1);
    step("upd40b", 0, 0, 1, 32'h40, 1, 0, 1);
    step("upd40c", 0, 0, 1, 32'h40, 1, 1, 1);
    step("lkp40b", 1, 32'h40, 0, 0, 0, 0, 1);
    check("lkp40b.stt_const", 32'(bus.pred_stt), 32'd3);
    check("lkp40b.mis_const", 32'(bus.mis_cnt),  32'd2);
    check("lkp40b.br_const",  32'(bus.br_cnt),   32'd3);

    // Saturation at strong not-taken.
    for (int k = 0; k < 5; k++) step("upd44", 0, 0, 1, 32'h44, 0, 0, 1);
    step("lkp44", 1, 32'h44, 0, 0, 0, 0, 1);
    check("lkp44.stt_const", 32'(bus.pred_stt), 32'd0);

    // Write-first bypass, then an aliased PC sharing the counter.
    step("byp48", 1, 32'h48, 1, 32'h48, 1, 1, 1);
    check("byp48.stt_const", 32'(bus.pred_stt), 32'd2);
    step("alias48", 1, 32'h48 + 4 * ENTRIES, 0, 0, 0, 0, 1);
    check("alias48.stt_const", 32'(bus.pred_stt), 32'd2);

    // Back-to-back accumulate from 00: two taken updates end at 10.
    step("acc44a", 0, 0, 1, 32'h44, 1, 0, 1);
    step("acc44b", 1, 32'h44, 1, 32'h44, 1, 1, 1);
    check("acc44.stt_const", 32'(bus.pred_stt), 32'd2);

    // Random mixed traffic on a small PC range to force collisions.
    for (int k = 0; k < 300; k++) begin
      lpc = PC_W'($urandom_range(0, 47)) << 2;
      upc = PC_W'($urandom_range(0, 47)) << 2;
      step("rand", 1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), upc,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end

    // Mid-stream reset with an update and lookup pending.
    bus.lkp_vld        = 1'b1;
    bus.lkp_pc         = 32'h40;
    bus.upd_vld        = 1'b1;
    bus.upd_pc         = 32'h40;
    bus.upd_taken      = 1'b1;
    bus.upd_pred_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(posedge clk);
    #1 check_all("midrst_hold");
    idle();
    @(negedge clk) rst_n = 1'b1;
    step("post40", 1, 32'h40, 0, 0, 0, 0, 1);
    step("post44", 1, 32'h44, 0, 0, 0, 0, 1);
    step("post48", 1, 32'h48, 0, 0, 0, 0, 1);
    check("post48.stt_const", 32'(bus.pred_stt), 32'd1);

    // Statistics saturation: 65,540 mispredicting updates.
    for (int k = 0; k < 65540; k++) begin
      ut  = 1'($urandom_range(0, 1));
      upc = PC_W'($urandom_range(0, 63)) << 2;
      step("bulk", 0, 0, 1, upc, ut, ~ut, (k % 8192 == 0) || (k >= 65530));
    end
    check("sat.br_const",  32'(bus.br_cnt),  32'hFFFF);
    check("sat.mis_const", 32'(bus.mis_cnt), 32'hFFFF);
    step("sat_hold", 1, 32'h40, 1, 32'h40, 1, 0, 1);
    step("sat_hold2", 0, 0, 1, 32'h44, 0, 0, 1);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
